fetch_ctrl: RTL and testbench

- Pipeline sequencing controller for the program counter and the IF/ID, ID/EX and EX/MEM pipeline registers.
- Generates `pc_en` and the per-stage enable and flush controls from the following inputs: instruction-cache hit, data-cache stall, load-use hazard, EX-stage branch/JALR redirect, and halt request.
- Holds a redirect that arrives while an instruction fetch is outstanding, and replays it to the PC once the fetch completes.
- Provides a post-reset boot delay and a saturating stall-cycle counter.

---
 rtl/fetch_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_fetch_ctrl.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: PC and IF/ID, ID/EX, EX/MEM sequencing control.
// Boot delay, held/replayed redirects, halt, stall-cycle counter.
//
// Ports:
//   clk, rst (async, active low)
//   icache_hit, dcache_stall, load_use, halt_req
//   ex_pcsrc, ex_jalr, ex_pctarget, ex_aluout : EX redirect
//   pc_en, pc_src, pc_jalr, pc_target, pc_aluout : PC control
//   fd_en, de_en, em_en, fd_flush, de_flush : pipe regs
//   halted, stall_cnt
module fetch_ctrl #(
  parameter int BOOT_CYCLES = 4,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             icache_hit,
  input  logic             dcache_stall,
  input  logic             load_use,
  input  logic             ex_pcsrc,
  input  logic             ex_jalr,
  input  logic [31:0]      ex_pctarget,
  input  logic [31:0]      ex_aluout,
  input  logic             halt_req,
  output logic             pc_en,
  output logic             pc_src,
  output logic             pc_jalr,
  output logic [31:0]      pc_target,
  output logic [31:0]      pc_aluout,
  output logic             fd_en,
  output logic             de_en,
  output logic             em_en,
  output logic             fd_flush,
  output logic             de_flush,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int BCW =
    (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;
  localparam logic [BCW-1:0] BOOT_INIT =
    (BOOT_CYCLES > 0) ? BCW'(BOOT_CYCLES - 1) : '0;

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } state_t;

  localparam state_t RST_STATE =
    (BOOT_CYCLES == 0) ? RUN : BOOT;

  state_t          state;
  logic [BCW-1:0]  boot_cnt;
  logic            redir_pend;
  logic            lat_pcsrc;
  logic            lat_jalr;
  logic [31:0]     lat_target;
  logic [31:0]     lat_aluout;

  logic run, act, redir, lu_eff, nr;
  logic in_boot, in_halt;
  logic r_stall, r_halt, r_redir;
  logic r_lu, r_miss, r_go;

  // Reset forces boot outputs even when RST_STATE is RUN.
  assign in_boot = ~rst | (state == BOOT);
  assign in_halt = rst & (state == HALTED);
  assign run     = rst & (state == RUN);

  assign redir   = ex_pcsrc | ex_jalr;
  // ID holds a bubble while a redirect is pending.
  assign lu_eff  = load_use & ~redir_pend;

  assign r_stall = run & dcache_stall;
  assign r_halt  = run & ~dcache_stall & halt_req;
  assign act     = run & ~dcache_stall & ~halt_req;
  assign r_redir = act & redir;
  assign r_lu    = act & ~redir & lu_eff;
  assign nr      = act & ~redir & ~lu_eff;
  assign r_miss  = nr & ~icache_hit;
  assign r_go    = nr & icache_hit;

  always_comb begin
    pc_en     = 1'b0;
    pc_src    = 1'b0;
    pc_jalr   = 1'b0;
    fd_en     = 1'b0;
    de_en     = 1'b0;
    em_en     = 1'b0;
    fd_flush  = 1'b0;
    de_flush  = 1'b0;
    halted    = 1'b0;
    pc_target = redir_pend ? lat_target : ex_pctarget;
    pc_aluout = redir_pend ? lat_aluout : ex_aluout;
    unique case (1'b1)
      in_boot: begin
        fd_en     = 1'b1;
        de_en     = 1'b1;
        fd_flush  = 1'b1;
        de_flush  = 1'b1;
        pc_target = '0;
        pc_aluout = '0;
      end
      in_halt: begin
        halted = 1'b1;
      end
      r_stall, r_halt: begin
      end
      r_redir: begin
        fd_en    = 1'b1;
        de_en    = 1'b1;
        em_en    = 1'b1;
        fd_flush = 1'b1;
        de_flush = 1'b1;
        if (icache_hit) begin
          pc_en     = 1'b1;
          pc_src    = ex_pcsrc;
          pc_jalr   = ex_jalr;
          pc_target = ex_pctarget;
          pc_aluout = ex_aluout;
        end
      end
      r_lu: begin
        de_en    = 1'b1;
        de_flush = 1'b1;
        em_en    = 1'b1;
      end
      r_miss: begin
        fd_en    = 1'b1;
        fd_flush = 1'b1;
        de_en    = 1'b1;
        em_en    = 1'b1;
      end
      r_go: begin
        pc_en = 1'b1;
        fd_en = 1'b1;
        de_en = 1'b1;
        em_en = 1'b1;
        // Replay: the word fetched is off-path.
        if (redir_pend) begin
          pc_src   = lat_pcsrc;
          pc_jalr  = lat_jalr;
          fd_flush = 1'b1;
        end
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= RST_STATE;
      boot_cnt   <= BOOT_INIT;
      redir_pend <= 1'b0;
      lat_pcsrc  <= 1'b0;
      lat_jalr   <= 1'b0;
      lat_target <= '0;
      lat_aluout <= '0;
      stall_cnt  <= '0;
    end else begin
      case (state)
        BOOT: begin
          if (boot_cnt == '0) state <= RUN;
          else boot_cnt <= boot_cnt - BCW'(1);
        end
        RUN: begin
          if (r_halt) state <= HALTED;
        end
        HALTED: begin
        end
        default: state <= RST_STATE;
      endcase

      // Newest redirect overwrites any pending one.
      if (r_redir && !icache_hit) begin
        redir_pend <= 1'b1;
        lat_pcsrc  <= ex_pcsrc;
        lat_jalr   <= ex_jalr;
        lat_target <= ex_pctarget;
        lat_aluout <= ex_aluout;
      end else if ((r_redir && icache_hit) ||
                   (r_go && redir_pend)) begin
        redir_pend <= 1'b0;
      end

      if (run && !pc_en && stall_cnt != '1)
        stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: vector table, directed corner sequences and
// randomized stimulus against a rule-level reference model.
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        icache_hit, dcache_stall, load_use;
  logic        ex_pcsrc, ex_jalr, halt_req;
  logic [31:0] ex_pctarget, ex_aluout;
  logic        pc_en, pc_src, pc_jalr;
  logic [31:0] pc_target, pc_aluout;
  logic        fd_en, de_en, em_en, fd_flush, de_flush;
  logic        halted;
  logic [3:0]  stall_cnt;

  always #5 clk = ~clk;

  fetch_ctrl #(.BOOT_CYCLES(4), .CNT_W(4)) dut (
    .clk(clk), .rst(rst),
    .icache_hit(icache_hit), .dcache_stall(dcache_stall),
    .load_use(load_use), .ex_pcsrc(ex_pcsrc),
    .ex_jalr(ex_jalr), .ex_pctarget(ex_pctarget),
    .ex_aluout(ex_aluout), .halt_req(halt_req),
    .pc_en(pc_en), .pc_src(pc_src), .pc_jalr(pc_jalr),
    .pc_target(pc_target), .pc_aluout(pc_aluout),
    .fd_en(fd_en), .de_en(de_en), .em_en(em_en),
    .fd_flush(fd_flush), .de_flush(de_flush),
    .halted(halted), .stall_cnt(stall_cnt)
  );

  typedef struct packed {
    logic hit, dst, lu, src, jalr, halt;
    logic [31:0] tgt, alu;
  } in_t;

  typedef struct packed {
    logic pc_en, pc_src, pc_jalr;
    logic fd_en, de_en, em_en;
    logic fd_flush, de_flush, halted;
    logic [31:0] tgt, alu;
    logic [3:0]  cnt;
  } out_t;

  typedef struct packed {
    in_t  i;
    out_t o;
  } vec_t;

  // {pc_en,pc_src,pc_jalr,fd_en,de_en,em_en,fd_flush,de_flush,halted}
  localparam logic [8:0] C_BOOT   = 9'b000110110;
  localparam logic [8:0] C_RUN    = 9'b100111000;
  localparam logic [8:0] C_LU     = 9'b000011010;
  localparam logic [8:0] C_BR     = 9'b110111110;
  localparam logic [8:0] C_BOTH   = 9'b111111110;
  localparam logic [8:0] C_RMISS  = 9'b000111110;
  localparam logic [8:0] C_MISS   = 9'b000111100;
  localparam logic [8:0] C_REPJ   = 9'b101111100;
  localparam logic [8:0] C_FREEZE = 9'b000000000;

  int npass = 0;
  int nchk  = 0;
  in_t  cur;
  vec_t vecs [18];

  // Reference model state
  int          m_boot, m_cnt;
  bit          m_halt, m_pend;
  logic        m_ps, m_pj;
  logic [31:0] m_pt, m_pa;

  function automatic in_t mi(input logic hit, input logic dst,
                             input logic lu, input logic src,
                             input logic jalr, input logic halt,
                             input logic [31:0] tgt,
                             input logic [31:0] alu);
    in_t x;
    x.hit = hit; x.dst = dst; x.lu = lu;
    x.src = src; x.jalr = jalr; x.halt = halt;
    x.tgt = tgt; x.alu = alu;
    return x;
  endfunction

  function automatic out_t mo(input logic [8:0] c,
                              input logic [31:0] tgt,
                              input logic [31:0] alu,
                              input logic [3:0] cnt);
    out_t o;
    {o.pc_en, o.pc_src, o.pc_jalr, o.fd_en, o.de_en,
     o.em_en, o.fd_flush, o.de_flush, o.halted} = c;
    o.tgt = tgt; o.alu = alu; o.cnt = cnt;
    return o;
  endfunction

  function automatic logic [8:0] ctl(input out_t o);
    return {o.pc_en, o.pc_src, o.pc_jalr, o.fd_en, o.de_en,
            o.em_en, o.fd_flush, o.de_flush, o.halted};
  endfunction

  task automatic model_reset();
    m_boot = 4; m_cnt = 0;
    m_halt = 0; m_pend = 0;
    m_ps = 0; m_pj = 0; m_pt = '0; m_pa = '0;
  endtask

  function automatic out_t model_out(input in_t x);
    out_t o = '0;
    o.cnt = 4'(m_cnt);
    if (m_boot > 0) begin
      o.fd_en = 1; o.de_en = 1;
      o.fd_flush = 1; o.de_flush = 1;
      return o;
    end
    if (m_halt) begin
      o.halted = 1;
      return o;
    end
    o.tgt = m_pend ? m_pt : x.tgt;
    o.alu = m_pend ? m_pa : x.alu;
    if (x.dst || x.halt) return o;
    if (x.src || x.jalr) begin
      o.fd_en = 1; o.de_en = 1; o.em_en = 1;
      o.fd_flush = 1; o.de_flush = 1;
      if (x.hit) begin
        o.pc_en = 1; o.pc_src = x.src; o.pc_jalr = x.jalr;
        o.tgt = x.tgt; o.alu = x.alu;
      end
      return o;
    end
    if (x.lu && !m_pend) begin
      o.de_en = 1; o.de_flush = 1; o.em_en = 1;
      return o;
    end
    o.fd_en = 1; o.de_en = 1; o.em_en = 1;
    if (!x.hit) begin
      o.fd_flush = 1;
      return o;
    end
    o.pc_en = 1;
    if (m_pend) begin
      o.pc_src = m_ps; o.pc_jalr = m_pj; o.fd_flush = 1;
    end
    return o;
  endfunction

  task automatic model_step(input in_t x, input out_t e);
    if (m_boot > 0) begin
      m_boot--;
      return;
    end
    if (m_halt) return;
    if (!e.pc_en && m_cnt < 15) m_cnt++;
    if (x.dst) return;
    if (x.halt) begin
      m_halt = 1;
      return;
    end
    if (x.src || x.jalr) begin
      if (x.hit) m_pend = 0;
      else begin
        m_pend = 1; m_ps = x.src; m_pj = x.jalr;
        m_pt = x.tgt; m_pa = x.alu;
      end
      return;
    end
    if (x.lu && !m_pend) return;
    if (x.hit) m_pend = 0;
  endtask

  task automatic drive(input in_t x);
    cur          = x;
    icache_hit   = x.hit;
    dcache_stall = x.dst;
    load_use     = x.lu;
    ex_pcsrc     = x.src;
    ex_jalr      = x.jalr;
    halt_req     = x.halt;
    ex_pctarget  = x.tgt;
    ex_aluout    = x.alu;
  endtask

  function automatic out_t sample();
    out_t o;
    o.pc_en = pc_en; o.pc_src = pc_src; o.pc_jalr = pc_jalr;
    o.fd_en = fd_en; o.de_en = de_en; o.em_en = em_en;
    o.fd_flush = fd_flush; o.de_flush = de_flush;
    o.halted = halted;
    o.tgt = pc_target; o.alu = pc_aluout; o.cnt = stall_cnt;
    return o;
  endfunction

  task automatic check(input string nm, input out_t e);
    out_t a = sample();
    // Targets are not defined while halted.
    if (e.halted) begin
      a.tgt = '0; a.alu = '0;
    end
    nchk++;
    if (a === e) npass++;
    else
      $display("FAIL %s: ctl=%b tgt=%h alu=%h cnt=%0d, expected ctl=%b tgt=%h alu=%h cnt=%0d",
               nm, ctl(a), a.tgt, a.alu, a.cnt,
               ctl(e), e.tgt, e.alu, e.cnt);
  endtask

  task automatic check_val(input string nm,
                           input logic [31:0] a,
                           input logic [31:0] e);
    nchk++;
    if (a === e) npass++;
    else $display("FAIL %s: got %h expected %h", nm, a, e);
  endtask

  task automatic step(input in_t x, input string nm);
    out_t e;
    drive(x);
    #3;
    e = model_out(x);
    check(nm, e);
    model_step(x, e);
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_rst(input string nm);
    rst = 1'b0;
    #1;
    model_reset();
    check(nm, model_out(cur));
    rst = 1'b1;
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    out_t e;
    in_t  x;
    in_t  idle;
    rst = 1'b0;
    drive('0);
    model_reset();
    idle = mi(1, 0, 0, 0, 0, 0, 0, 0);

    vecs[0]  = {mi(1,0,0,1,0,0,32'h12345678,0), mo(C_BOOT,0,0,0)};
    vecs[1]  = {idle, mo(C_BOOT, 0, 0, 0)};
    vecs[2]  = {idle, mo(C_BOOT, 0, 0, 0)};
    vecs[3]  = {idle, mo(C_BOOT, 0, 0, 0)};
    vecs[4]  = {idle, mo(C_RUN, 0, 0, 0)};
    vecs[5]  = {mi(1,0,1,0,0,0,0,0), mo(C_LU, 0, 0, 0)};
    vecs[6]  = {idle, mo(C_RUN, 0, 0, 1)};
    vecs[7]  = {mi(1,0,0,1,0,0,32'hBFC00040,0),
                mo(C_BR, 32'hBFC00040, 0, 1)};
    vecs[8]  = {mi(0,0,0,0,1,0,0,32'hBFC00100),
                mo(C_RMISS, 0, 32'hBFC00100, 1)};
    vecs[9]  = {mi(0,0,0,0,0,0,0,0),
                mo(C_MISS, 0, 32'hBFC00100, 2)};
    vecs[10] = {mi(0,0,0,0,0,0,0,0),
                mo(C_MISS, 0, 32'hBFC00100, 3)};
    vecs[11] = {idle, mo(C_REPJ, 0, 32'hBFC00100, 4)};
    vecs[12] = {idle, mo(C_RUN, 0, 0, 4)};
    vecs[13] = {mi(1,1,1,1,0,0,32'h80000000,0),
                mo(C_FREEZE, 32'h80000000, 0, 4)};
    vecs[14] = {mi(1,0,1,1,0,0,32'h80000000,0),
                mo(C_BR, 32'h80000000, 0, 5)};
    vecs[15] = {mi(0,0,0,0,1,0,0,32'h200),
                mo(C_RMISS, 0, 32'h200, 5)};
    vecs[16] = {mi(1,0,1,0,0,0,0,0),
                mo(C_REPJ, 0, 32'h200, 6)};
    vecs[17] = {mi(1,0,0,1,1,0,32'h44,32'h88),
                mo(C_BOTH, 32'h44, 32'h88, 6)};

    @(posedge clk);
    #1;
    drive(mi(1,0,1,1,1,1,32'h12345678,32'h9));
    #1;
    check("in_reset", mo(C_BOOT, 0, 0, 0));
    @(posedge clk);
    #1;
    rst = 1'b1;

    for (int k = 0; k < 18; k++) begin
      drive(vecs[k].i);
      #3;
      check($sformatf("vec%0d", k), vecs[k].o);
      e = model_out(vecs[k].i);
      model_step(vecs[k].i, e);
      @(posedge clk);
      #1;
    end

    // Counter saturation after a long icache miss.
    drive(mi(0,0,0,0,0,0,0,0));
    pulse_rst("rst_run");
    for (int k = 0; k < 24; k++)
      step(mi(0,0,0,0,0,0,0,0), "sat");
    check_val("sat_cnt", 32'(stall_cnt), 32'd15);

    // Halt, then async reset pulse between clock edges.
    step(mi(1,0,0,0,0,1,0,0), "halt_req");
    for (int k = 0; k < 3; k++)
      step(mi(1,0,1,1,0,0,32'hA0,0), "halted");
    check_val("halted_flag", 32'(halted), 32'd1);
    check_val("halted_pc_en", 32'(pc_en), 32'd0);
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    check("halt_rst", model_out(cur));
    check_val("halt_rst_flag", 32'(halted), 32'd0);
    rst = 1'b1;
    #1;
    for (int k = 0; k < 5; k++) step(idle, "reboot");
    check_val("reboot_pc_en", 32'(pc_en), 32'd1);

    for (int i = 0; i < 600; i++) begin
      if (i % 50 == 25) pulse_rst("rand_rst");
      x = mi($urandom_range(0, 3) != 0,
             $urandom_range(0, 5) == 0,
             $urandom_range(0, 3) == 0,
             $urandom_range(0, 4) == 0,
             $urandom_range(0, 5) == 0,
             $urandom_range(0, 79) == 0,
             $urandom, $urandom);
      step(x, "rand");
    end

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
